dmem_responder: RTL

- Multi-cycle data-memory responder at the far end of the CPU MEM-stage load/store interface.
- Accepts one read or write request at a time from the pipeline and services it after a fixed, parameterised latency.
- Returns read data, completion, error and stall indications so the pipeline can freeze while an access is in flight.
- Replaces the single-cycle data memory when slow-memory behaviour is modelled.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    // Word-index width; at least one bit so slices stay legal for tiny memories.
    function automatic int idx_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read, no reset.
module dmem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // The read register only moves on a read, so it holds across writes.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: accepts one request, completes it LATENCY
// cycles later with a one-cycle valid pulse, and stalls the pipeline meanwhile.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ack_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              stall_o
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              valid_q;
    logic              err_q;
    logic              rd_ok_q;

    logic              accept;
    logic              enter_done;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_err;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = (state_q == IDLE) && req_i;

    // With LATENCY==1 the access happens on the accepting edge, before the
    // latch holds the request, so the live fields are used in that case.
    assign acc_we    = (state_q == IDLE) ? we_i    : we_q;
    assign acc_addr  = (state_q == IDLE) ? addr_i  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
    assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                       ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_done = (state_d == DONE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            valid_q <= enter_done;
            err_q   <= enter_done && acc_err;
            // Read-data visibility: set by a good read, cleared by a failed one.
            if (enter_done && !acc_we) begin
                rd_ok_q <= !acc_err;
            end
        end
    end

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (enter_done && !acc_err),
        .we_i    (acc_we),
        .idx_i   (acc_addr[IDX_W+1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    assign ack_o   = accept;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign rdata_o = rd_ok_q ? arr_rdata : '0;
    assign stall_o = req_i && !valid_q;

endmodule
